load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 243 ++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges a RISC-V style load/store request from the core onto a simple
//   word-wide data memory. Loads extract a byte, halfword or word and
//   sign/zero-extend it. Stores write whole words directly. Byte and halfword
//   stores do a read-modify-write of the containing word. Each request gets
//   exactly one response, and a new request is only taken once that response
//   has been handed off.
//
// Parameters
//   MISALIGN_ERR  1: misaligned accesses respond with an error and never touch
//                    memory
//                 0: low address bits are dropped to force natural alignment
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid / req_ready     request handshake
//   req_we                    1 = store, 0 = load
//   req_funct3                RISC-V funct3 access size/sign code
//   req_addr                  byte address
//   req_wdata                 store data, right-aligned
//   resp_valid / resp_ready   response handshake
//   resp_rdata                extended load result (0 for stores/errors)
//   resp_err                  misaligned access or illegal funct3
//   mem_we, mem_addr, mem_wd  word write enable, word address, write data
//   mem_rd                    combinational read data for mem_addr
module load_store_unit #(
  parameter bit MISALIGN_ERR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t state;
  state_t state_next;

  // ready_en stays low through reset and rises on the first edge after it.
  // This keeps req_ready low while rst is high, and raises it one edge after
  // rst is released.
  logic ready_en;

  logic        accept;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merged_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        req_is_half;
  logic        req_is_word;
  logic        req_illegal;
  logic        req_misaligned;
  logic        req_error;
  logic [31:0] req_addr_aligned;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;
  logic [31:0] st_merged;

  // Request decode. The aligned address is always latched. When
  // MISALIGN_ERR=1 a misaligned request never reaches memory, so the
  // alignment has no effect in that mode.
  always_comb begin
    req_is_half = (req_funct3[1:0] == 2'b01);
    req_is_word = (req_funct3[1:0] == 2'b10);
    if (req_we) begin
      req_illegal = (req_funct3 > 3'b010);
    end else begin
      req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end
    req_misaligned = (req_is_half && req_addr[0]) ||
                     (req_is_word && (req_addr[1:0] != 2'b00));
    req_error = req_illegal || (MISALIGN_ERR && req_misaligned);
    req_addr_aligned = req_addr;
    if (req_is_word) begin
      req_addr_aligned[1:0] = 2'b00;
    end else if (req_is_half) begin
      req_addr_aligned[0] = 1'b0;
    end
  end

  // Load lane selection and extension.
  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_byte = mem_rd[7:0];
      2'b01:   ld_byte = mem_rd[15:8];
      2'b10:   ld_byte = mem_rd[23:16];
      default: ld_byte = mem_rd[31:24];
    endcase
    ld_half = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (funct3_q)
      3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_value = mem_rd;
      3'b100:  ld_value = {24'h000000, ld_byte};
      3'b101:  ld_value = {16'h0000, ld_half};
      default: ld_value = 32'h0000_0000;
    endcase
  end

  // Sub-word store merge. funct3 bit 0 separates SH (1) from SB (0). Only
  // those two store types ever reach RMW_RD.
  always_comb begin
    st_merged = mem_rd;
    if (funct3_q[0]) begin
      if (addr_q[1]) begin
        st_merged[31:16] = wdata_q[15:0];
      end else begin
        st_merged[15:0] = wdata_q[15:0];
      end
    end else begin
      case (addr_q[1:0])
        2'b00:   st_merged[7:0]   = wdata_q[7:0];
        2'b01:   st_merged[15:8]  = wdata_q[7:0];
        2'b10:   st_merged[23:16] = wdata_q[7:0];
        default: st_merged[31:24] = wdata_q[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ready_en <= 1'b0;
    end else begin
      state    <= state_next;
      ready_en <= 1'b1;
    end
  end

  // Memory outputs are driven purely from the state. An asynchronous reset
  // therefore drops mem_we before the next edge, so no write can commit.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    accept     = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'h0000_0000;
    mem_wd     = 32'h0000_0000;
    case (state)
      IDLE: begin
        req_ready = ready_en;
        accept    = req_valid && ready_en;
        if (accept) begin
          if (req_error) begin
            state_next = RESP;
          end else if (!req_we) begin
            state_next = LOAD;
          end else if (req_funct3 == 3'b010) begin
            state_next = STORE;
          end else begin
            state_next = RMW_RD;
          end
        end
      end
      LOAD: begin
        mem_addr   = {addr_q[31:2], 2'b00};
        state_next = RESP;
      end
      STORE: begin
        mem_addr   = {addr_q[31:2], 2'b00};
        mem_we     = 1'b1;
        mem_wd     = wdata_q;
        state_next = RESP;
      end
      RMW_RD: begin
        mem_addr   = {addr_q[31:2], 2'b00};
        state_next = RMW_WR;
      end
      RMW_WR: begin
        mem_addr   = {addr_q[31:2], 2'b00};
        mem_we     = 1'b1;
        mem_wd     = merged_q;
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request capture and result registers. The result is cleared on accept,
  // so stores and errors respond with zero data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      funct3_q <= 3'b000;
      addr_q   <= 32'h0000_0000;
      wdata_q  <= 32'h0000_0000;
      merged_q <= 32'h0000_0000;
      rdata_q  <= 32'h0000_0000;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        funct3_q <= req_funct3;
        addr_q   <= req_addr_aligned;
        wdata_q  <= req_wdata;
        rdata_q  <= 32'h0000_0000;
        err_q    <= req_error;
      end
      if (state == LOAD) begin
        rdata_q <= ld_value;
      end
      if (state == RMW_RD) begin
        merged_q <= st_merged;
      end
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Self-checking bench for load_store_unit (MISALIGN_ERR=1). It provides a
//   256-byte word memory behind the DUT and a byte-level reference memory.
//   Stimulus comes from three sources: a table of directed vectors,
//   hand-written handshake and reset sequences, and randomized transactions
//   checked against a byte-array reference model.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  int nvec = 0;
  int nmis = 0;
  int we_pulses = 0;

  logic [31:0] mem [64] = '{default: 32'h0};
  logic [7:0]  ref_bytes [256];

  logic        preset_en = 1'b0;
  logic [5:0]  preset_idx = 6'd0;
  logic [31:0] preset_word = 32'h0;

  load_store_unit #(.MISALIGN_ERR(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_funct3(req_funct3),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Data memory: combinational read, write on the rising edge.
  assign mem_rd = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (preset_en) begin
      mem[preset_idx] <= preset_word;
    end else if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wd;
      we_pulses <= we_pulses + 1;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nvec++;
    if (actual !== expected) begin
      nmis++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic presetWord(input int a, input logic [31:0] w);
    preset_en   = 1'b1;
    preset_idx  = 6'(a >> 2);
    preset_word = w;
    @(posedge clk);
    #1;
    preset_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ref_bytes[(a & ~3) + i] = 8'(w >> (8 * i));
    end
  endtask

  // Byte-level model of the unit's behaviour.
  task automatic refModel(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat, output int wes);
    int size;
    int a;
    bit legal;
    longint v;
    a = int'(addr);
    size = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
    if (we) legal = (f3 <= 3'd2);
    else legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    rdata = 32'h0;
    err = 1'b0;
    wes = 0;
    lat = 1;
    if (!legal || (a % size) != 0) begin
      err = 1'b1;
    end else if (!we) begin
      v = 0;
      for (int i = 0; i < size; i++) begin
        v = v + (longint'(ref_bytes[a + i]) << (8 * i));
      end
      if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1))) begin
        v = v - (longint'(1) << (8 * size));
      end
      rdata = v[31:0];
      lat = 2;
    end else begin
      for (int i = 0; i < size; i++) begin
        ref_bytes[a + i] = 8'(wdata >> (8 * i));
      end
      lat = (size == 4) ? 2 : 3;
      wes = 1;
    end
  endtask

  // Runs one full transaction. If hold > 0, resp_ready is held low for that
  // many cycles, and a competing store request is kept pending. The DUT must
  // not take that store before the response handshake.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input int hold,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               output logic [31:0] rdata, output logic err,
                               output int lat, output int wes);
    int waitc;
    int start;
    waitc = 0;
    while (req_ready !== 1'b1 && waitc < 10) begin
      @(posedge clk);
      #1;
      waitc++;
    end
    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    resp_ready = (hold == 0);
    start = we_pulses;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("resp_valid_seen", 32'(resp_valid), 32'd1);
    rdata = resp_rdata;
    err   = resp_err;
    if (hold > 0) begin
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h0;
      req_wdata  = 32'hFFFF_FFFF;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        checkOutput("hold_resp_valid", 32'(resp_valid), 32'd1);
        checkOutput("hold_resp_rdata", resp_rdata, exp_rdata);
        checkOutput("hold_resp_err", 32'(resp_err), 32'(exp_err));
        checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    wes = we_pulses - start;
    checkOutput("resp_released", 32'(resp_valid), 32'd0);
    checkOutput("req_ready_after", 32'(req_ready), 32'd1);
  endtask

  typedef struct {
    bit          pre;
    logic [31:0] pre_word;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wes;
    bit          chk_mem;
    logic [31:0] exp_mem;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  initial begin
    logic [31:0] rdata;
    logic [31:0] m_rdata;
    logic        err;
    logic        m_err;
    int          lat;
    int          m_lat;
    int          wes;
    int          m_wes;
    int          start;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    int          r_hold;

    vecs[0]  = '{1'b1, 32'h12345678, 1'b0, 3'b000, 32'd9,  32'h0, 32'h00000056, 1'b0, 2, 0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0,        1'b0, 3'b000, 32'd11, 32'h0, 32'h00000012, 1'b0, 2, 0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0,        1'b0, 3'b001, 32'd10, 32'h0, 32'h00001234, 1'b0, 2, 0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0,        1'b0, 3'b100, 32'd8,  32'h0, 32'h00000078, 1'b0, 2, 0, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h0,        1'b0, 3'b010, 32'd8,  32'h0, 32'h12345678, 1'b0, 2, 0, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 32'h000080F0, 1'b0, 3'b000, 32'd8,  32'h0, 32'hFFFFFFF0, 1'b0, 2, 0, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 32'h0,        1'b0, 3'b001, 32'd8,  32'h0, 32'hFFFF80F0, 1'b0, 2, 0, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'h0,        1'b0, 3'b101, 32'd8,  32'h0, 32'h000080F0, 1'b0, 2, 0, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 32'h00000000, 1'b1, 3'b000, 32'd17, 32'h000000AB, 32'h0, 1'b0, 3, 1, 1'b1, 32'h0000AB00};
    vecs[9]  = '{1'b0, 32'h0,        1'b1, 3'b001, 32'd18, 32'h0000CDEF, 32'h0, 1'b0, 3, 1, 1'b1, 32'hCDEFAB00};
    vecs[10] = '{1'b0, 32'h0,        1'b1, 3'b010, 32'd20, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 1'b1, 32'hDEADBEEF};
    vecs[11] = '{1'b0, 32'h0,        1'b0, 3'b010, 32'd6,  32'h0, 32'h0, 1'b1, 1, 0, 1'b1, 32'h0};
    vecs[12] = '{1'b0, 32'h0,        1'b1, 3'b001, 32'd5,  32'h00001234, 32'h0, 1'b1, 1, 0, 1'b1, 32'h0};
    vecs[13] = '{1'b0, 32'h0,        1'b0, 3'b011, 32'd8,  32'h0, 32'h0, 1'b1, 1, 0, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 32'h0,        1'b0, 3'b110, 32'd8,  32'h0, 32'h0, 1'b1, 1, 0, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 32'h0,        1'b1, 3'b100, 32'd8,  32'hFFFFFFFF, 32'h0, 1'b1, 1, 0, 1'b1, 32'h000080F0};
    vecs[16] = '{1'b0, 32'h0,        1'b0, 3'b100, 32'd23, 32'h0, 32'h000000DE, 1'b0, 2, 0, 1'b0, 32'h0};
    vecs[17] = '{1'b0, 32'h0,        1'b0, 3'b000, 32'd22, 32'h0, 32'hFFFFFFAD, 1'b0, 2, 0, 1'b0, 32'h0};

    for (int i = 0; i < 256; i++) ref_bytes[i] = 8'h00;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;

    // Reset state
    @(posedge clk);
    #1;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_wd", mem_wd, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rel_req_ready_pre_edge", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rel_req_ready_post_edge", 32'(req_ready), 32'd1);

    // Directed vectors
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].pre) presetWord(int'(vecs[i].addr) & ~3, vecs[i].pre_word);
      refModel(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, m_rdata, m_err, m_lat, m_wes);
      applyStimulus(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 0,
                    vecs[i].exp_rdata, vecs[i].exp_err, rdata, err, lat, wes);
      checkOutput($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      checkOutput($sformatf("vec%0d_we_pulses", i), 32'(wes), 32'(vecs[i].exp_wes));
      if (vecs[i].chk_mem) begin
        checkOutput($sformatf("vec%0d_mem", i), mem[vecs[i].addr[7:2]], vecs[i].exp_mem);
      end
    end

    // Response back-pressure: resp_ready low for 4 cycles with a request pending
    refModel(1'b0, 3'b010, 32'd8, 32'h0, m_rdata, m_err, m_lat, m_wes);
    applyStimulus(1'b0, 3'b010, 32'd8, 32'h0, 4, 32'h000080F0, 1'b0, rdata, err, lat, wes);
    checkOutput("hold_rdata", rdata, 32'h000080F0);
    checkOutput("hold_latency", 32'(lat), 32'd2);
    checkOutput("hold_no_overlap_mem0", mem[0], 32'h0);
    applyStimulus(1'b0, 3'b100, 32'd8, 32'h0, 0, 32'h000000F0, 1'b0, rdata, err, lat, wes);
    checkOutput("after_hold_rdata", rdata, 32'h000000F0);

    // Reset during RMW_RD of an SB
    presetWord(24, 32'h11223344);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'd25;
    req_wdata  = 32'h00000055;
    start = we_pulses;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("rmw_rd_mem_addr", mem_addr, 32'd24);
    checkOutput("rmw_rd_mem_we", 32'(mem_we), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("rmw_rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rmw_rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rmw_rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rmw_rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rmw_rst_resp_rdata", resp_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rmw_rel_req_ready_pre", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rmw_rel_req_ready_post", 32'(req_ready), 32'd1);
    checkOutput("rmw_rel_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rmw_rel_we_pulses", 32'(we_pulses - start), 32'd0);
    checkOutput("rmw_rel_mem", mem[6], 32'h11223344);

    // Reset while a SW sits in STORE: the write must not commit
    presetWord(28, 32'hA5A5A5A5);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'd28;
    req_wdata  = 32'h0BADF00D;
    start = we_pulses;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("store_mem_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("store_rst_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("store_rst_mem", mem[7], 32'hA5A5A5A5);
    checkOutput("store_rst_we_pulses", 32'(we_pulses - start), 32'd0);
    checkOutput("store_rst_req_ready", 32'(req_ready), 32'd1);

    // Randomized transactions against the reference model
    for (int n = 0; n < 200; n++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_f3    = 3'($urandom_range(0, 7));
      r_addr  = 32'($urandom_range(0, 255));
      r_wdata = $urandom;
      r_hold  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      refModel(r_we, r_f3, r_addr, r_wdata, m_rdata, m_err, m_lat, m_wes);
      applyStimulus(r_we, r_f3, r_addr, r_wdata, r_hold, m_rdata, m_err, rdata, err, lat, wes);
      checkOutput($sformatf("rnd%0d_rdata", n), rdata, m_rdata);
      checkOutput($sformatf("rnd%0d_err", n), 32'(err), 32'(m_err));
      checkOutput($sformatf("rnd%0d_latency", n), 32'(lat), 32'(m_lat));
      checkOutput($sformatf("rnd%0d_we_pulses", n), 32'(wes), 32'(m_wes));
    end

    // Final memory image against the reference bytes
    for (int w = 0; w < 64; w++) begin
      checkOutput($sformatf("final_mem_word%0d", w), mem[w],
                  {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
